// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and helpers for the weighted-slice round-robin arbiter
// Contents:
//   state_t : arbiter FSM states (IDLE, GRANT)
//   MAX_N   : largest supported requester count
//   clog2   : ceiling log2 helper
//   id_w    : requester-index width for a given N (at least 1 bit)
//   onehot  : one-hot vector of MAX_N bits with bit id set (zero if id is out of range)
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int MAX_N = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int id_w(input int n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

    function automatic logic [MAX_N-1:0] onehot(input int id, input int n);
        logic [MAX_N-1:0] result;
        result = '0;
        if (id >= 0 && id < n) begin
            result = MAX_N'(1) << id;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating priority encoder
// Ports:
//   req    in  N     request vector
//   ptr    in  ID_W  index with highest priority this cycle (must be < N)
//   found  out 1     some request is set
//   win_id out ID_W  first set request scanning ptr, ptr+1, ..., N-1, 0, ...
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] win_id
);

    logic [2*N-1:0] doubled;
    logic [2*N-1:0] masked;
    logic           hit;

    // The upper copy of req covers the wrap-around, so masking off the bits
    // below ptr and taking the lowest set bit gives the rotating winner.
    assign doubled = {req, req};
    assign masked  = doubled & ({(2*N){1'b1}} << ptr);
    assign found   = |req;

    always_comb begin
        win_id = '0;
        hit    = 1'b0;
        for (int j = 0; j < 2*N; j++) begin
            if (masked[j] && !hit) begin
                win_id = ID_W'(j % N);
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_weighted_slices.sv
// rtl/rr_arbiter_weighted_slices.sv - round-robin arbiter with per-requester time slices
// Ports:
//   clk        in  1          rising-edge clock
//   rst_n      in  1          asynchronous active-low reset
//   REQ        in  N          level-sensitive request vector
//   slice_len  in  N*SLICE_W  per-requester slice length, sampled at grant; 0 acts as 1
//   GNT        out N          registered one-hot grant or zero
//   gnt_valid  out 1          registered |GNT
//   gnt_id     out ID_W       owner index, 0 when idle
//   slice_end  out 1          one-cycle pulse when the owner loses grant by slice expiry
module rr_arbiter_weighted_slices
    import arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int SLICE_W = 4,
    parameter int ID_W    = id_w(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         REQ,
    input  logic [N*SLICE_W-1:0] slice_len,
    output logic [N-1:0]         GNT,
    output logic                 gnt_valid,
    output logic [ID_W-1:0]      gnt_id,
    output logic                 slice_end
);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [SLICE_W-1:0]  cnt_q, cnt_d;
    logic [N-1:0]        gnt_q, gnt_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                valid_q, valid_d;
    logic                end_q, end_d;

    logic [ID_W-1:0]     succ;
    logic [ID_W-1:0]     pick_ptr;
    logic                found;
    logic [ID_W-1:0]     win_id;
    logic [MAX_N-1:0]    win_oh;
    logic [SLICE_W-1:0]  win_slice;
    logic [SLICE_W-1:0]  win_load;

    // Explicit wrap so non-power-of-2 N works.
    assign succ     = (id_q == ID_W'(N-1)) ? '0 : id_q + 1'b1;
    // While granting, re-arbitration starts just past the owner, which puts
    // the owner last in line and lets a sole requester be re-granted.
    assign pick_ptr = (state_q == GRANT) ? succ : ptr_q;

    rr_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req    (REQ),
        .ptr    (pick_ptr),
        .found  (found),
        .win_id (win_id)
    );

    assign win_oh    = onehot(int'(win_id), N);
    assign win_slice = slice_len[int'(win_id)*SLICE_W +: SLICE_W];
    // Counter holds remaining cycles after the current one; slice 0 acts as 1.
    assign win_load  = (win_slice == '0) ? '0 : win_slice - 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        valid_d = valid_q;
        end_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = win_oh[N-1:0];
                    id_d    = win_id;
                    valid_d = 1'b1;
                    cnt_d   = win_load;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (REQ[id_q] && cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Expiry wins over a simultaneous request drop.
                    end_d = (cnt_q == '0);
                    ptr_d = succ;
                    if (found) begin
                        gnt_d   = win_oh[N-1:0];
                        id_d    = win_id;
                        valid_d = 1'b1;
                        cnt_d   = win_load;
                    end else begin
                        gnt_d   = '0;
                        id_d    = '0;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                id_d    = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            end_q   <= end_d;
        end
    end

    assign GNT       = gnt_q;
    assign gnt_valid = valid_q;
    assign gnt_id    = id_q;
    assign slice_end = end_q;

endmodule

// File: tb/tb_rr_arbiter_weighted_slices.sv
// tb/tb_rr_arbiter_weighted_slices.sv - directed self-checking bench for the weighted-slice arbiter
module tb_rr_arbiter_weighted_slices;
    import arb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] slice_len;
    logic [3:0]  gnt;
    logic        gnt_valid;
    logic [1:0]  gnt_id;
    logic        slice_end;

    logic [4:0]  req5;
    logic [19:0] slice_len5;
    logic [4:0]  gnt5;
    logic        gnt_valid5;
    logic [2:0]  gnt_id5;
    logic        slice_end5;

    int checks;
    int failures;

    rr_arbiter_weighted_slices #(.N(4), .SLICE_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .REQ       (req),
        .slice_len (slice_len),
        .GNT       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .slice_end (slice_end)
    );

    rr_arbiter_weighted_slices #(.N(5), .SLICE_W(4)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .REQ       (req5),
        .slice_len (slice_len5),
        .GNT       (gnt5),
        .gnt_valid (gnt_valid5),
        .gnt_id    (gnt_id5),
        .slice_end (slice_end5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Test 1: all slices 2
    logic [3:0] t1_gnt [9] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1};
    logic       t1_end [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] t1_id  [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    // Test 2: slices {1,3,2,4}
    logic [3:0] t2_gnt [11] = '{4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h8, 4'h8, 4'h1};
    logic       t2_end [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    // Test 2b: all slices 0 behave as 1
    logic [3:0] t2b_gnt [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    logic       t2b_end [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    // Test 4: sole requester, slice 3
    logic       t4_end [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    // Test 6: N=5 all slices 1
    logic [4:0] t6_gnt [6] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h01};
    logic [2:0] t6_id  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

    initial begin
        int exp_id;
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        req        = '0;
        slice_len  = '0;
        req5       = '0;
        slice_len5 = '0;

        tick();
        tick();
        check("rst_gnt",   32'(gnt), 32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        check("rst_id",    32'(gnt_id), 32'h0);
        check("rst_end",   32'(slice_end), 32'h0);
        check("rst_ptr",   32'(dut.ptr_q), 32'h0);
        check("rst_cnt",   32'(dut.cnt_q), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        tick();
        check("idle_noreq_gnt", 32'(gnt), 32'h0);

        // Test 1
        slice_len = 16'h2222;
        req       = 4'hF;
        for (int k = 0; k < 9; k++) begin
            tick();
            check($sformatf("t1_gnt%0d", k),   32'(gnt), 32'(t1_gnt[k]));
            check($sformatf("t1_end%0d", k),   32'(slice_end), 32'(t1_end[k]));
            check($sformatf("t1_id%0d", k),    32'(gnt_id), 32'(t1_id[k]));
            check($sformatf("t1_valid%0d", k), 32'(gnt_valid), 32'h1);
        end

        // Test 2
        req = '0;
        do_reset();
        slice_len = 16'h4231;
        req       = 4'hF;
        for (int k = 0; k < 11; k++) begin
            tick();
            check($sformatf("t2_gnt%0d", k), 32'(gnt), 32'(t2_gnt[k]));
            check($sformatf("t2_end%0d", k), 32'(slice_end), 32'(t2_end[k]));
        end
        req = '0;
        do_reset();
        slice_len = 16'h0000;
        req       = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("t2b_gnt%0d", k), 32'(gnt), 32'(t2b_gnt[k]));
            check($sformatf("t2b_end%0d", k), 32'(slice_end), 32'(t2b_end[k]));
        end

        // Test 3: early release
        req = '0;
        do_reset();
        slice_len = 16'h0080;
        req       = 4'b0010;
        tick();
        check("t3_gnt_first", 32'(gnt), 32'h2);
        tick();
        tick();
        check("t3_gnt_hold", 32'(gnt), 32'h2);
        check("t3_cnt_hold", 32'(dut.cnt_q), 32'd5);
        req = 4'b0100;
        tick();
        check("t3_gnt_next", 32'(gnt), 32'h4);
        check("t3_end",      32'(slice_end), 32'h0);
        check("t3_ptr",      32'(dut.ptr_q), 32'd2);
        check("t3_id",       32'(gnt_id), 32'd2);

        // Test 4: sole requester
        req = '0;
        do_reset();
        slice_len = 16'h3000;
        req       = 4'b1000;
        for (int k = 0; k < 7; k++) begin
            tick();
            check($sformatf("t4_gnt%0d", k), 32'(gnt), 32'h8);
            check($sformatf("t4_end%0d", k), 32'(slice_end), 32'(t4_end[k]));
        end
        req = '0;
        tick();
        check("t4_off_gnt",   32'(gnt), 32'h0);
        check("t4_off_valid", 32'(gnt_valid), 32'h0);
        check("t4_off_id",    32'(gnt_id), 32'h0);
        check("t4_off_end",   32'(slice_end), 32'h0);
        check("t4_off_state", 32'(dut.state_q), 32'(IDLE));

        // Test 5: reset mid-grant, with the pointer moved away from 0 first
        do_reset();
        slice_len = 16'h1111;
        req       = 4'b0011;
        tick();
        check("t5_gnt_a", 32'(gnt), 32'h1);
        tick();
        check("t5_gnt_b", 32'(gnt), 32'h2);
        req = 4'b0100;
        tick();
        check("t5_gnt_c", 32'(gnt), 32'h4);
        check("t5_ptr_c", 32'(dut.ptr_q), 32'd2);
        rst_n = 1'b0;
        #1;
        check("t5_async_gnt",   32'(gnt), 32'h0);
        check("t5_async_valid", 32'(gnt_valid), 32'h0);
        tick();
        rst_n = 1'b1;
        req   = 4'hF;
        tick();
        check("t5_after_gnt", 32'(gnt), 32'h1);

        // Test 6: N=5 wrap
        req = '0;
        do_reset();
        slice_len5 = 20'h11111;
        req5       = 5'h1F;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("t6_gnt%0d", k), 32'(gnt5), 32'(t6_gnt[k]));
            check($sformatf("t6_id%0d", k),  32'(gnt_id5), 32'(t6_id[k]));
            check($sformatf("t6_oh%0d", k),  32'($onehot0(gnt5)), 32'h1);
            exp_id = 0;
            for (int b = 0; b < 5; b++) begin
                if (gnt5[b]) exp_id = b;
            end
            check($sformatf("t6_idc%0d", k), 32'(gnt_id5), 32'(exp_id));
            check($sformatf("t6_vc%0d", k),  32'(gnt_valid5), 32'(|gnt5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
